// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: turns symbolic instructions from a valid/ready stream
// into 32-bit MIPS-format words and writes them into consecutive imem slots.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err_illegal
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] DEPTH_W   = (ADDR_W + 2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_FULL
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_MULT = 4'd4,
    OP_DIV  = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9
  } op_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                pend_q, pend_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                err_q, err_d;

  logic                is_r;
  logic                enc_legal;
  logic [5:0]          funct;
  logic [5:0]          opcode;
  logic [31:0]         enc_word;
  logic [ADDR_W+1:0]   occupancy;
  logic                xfer;

  // Opcode/funct map shared with the control_unit decoder.
  always_comb begin
    is_r      = 1'b0;
    enc_legal = 1'b1;
    funct     = '0;
    opcode    = '0;
    case (in_op)
      OP_ADD:  begin is_r = 1'b1; funct = 6'b100000; end
      OP_SUB:  begin is_r = 1'b1; funct = 6'b100010; end
      OP_AND:  begin is_r = 1'b1; funct = 6'b100100; end
      OP_OR:   begin is_r = 1'b1; funct = 6'b100101; end
      OP_MULT: begin is_r = 1'b1; funct = 6'b011000; end
      OP_DIV:  begin is_r = 1'b1; funct = 6'b011010; end
      OP_LW:   opcode = 6'b100011;
      OP_SW:   opcode = 6'b101011;
      OP_BEQ:  opcode = 6'b000100;
      OP_BNE:  opcode = 6'b000101;
      default: enc_legal = 1'b0;
    endcase
    if (is_r) begin
      enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, funct};
    end else begin
      enc_word = {opcode, in_rs, in_rt, in_imm};
    end
  end

  // Accept only while loading and while the accepted-but-unwritten word still fits.
  always_comb begin
    occupancy = {1'b0, count_q} + (ADDR_W + 2)'(pend_q);
    in_ready  = (state_q == S_LOAD) && (occupancy < DEPTH_W);
    xfer      = in_valid && in_ready;
  end

  // Next state and datapath updates; the write stage runs independently of
  // the FSM so a final word accepted in LOAD still completes while in DONE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    pend_d  = 1'b0;
    wdata_d = wdata_q;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;

    if (pend_q) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W + 1)'(1);
      if (count_q == LAST_SLOT) begin
        full_d = 1'b1;
        if (state_q == S_LOAD) begin
          state_d = S_FULL;
        end
      end
    end

    if (xfer) begin
      if (enc_legal) begin
        pend_d  = 1'b1;
        wdata_d = enc_word;
      end else begin
        err_d = 1'b1;
      end
      if (in_last) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    // A restart lets a write already on the bus finish, then rewinds.
    if (start && (state_q != S_LOAD)) begin
      state_d = S_LOAD;
      addr_d  = BASE;
      count_d = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address, count, pending write and sticky status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= BASE;
      count_q <= '0;
      pend_q  <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign imem_we     = pend_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign done        = done_q;
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule
